// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph table, segment bit positions and width helper for the 7-segment scan driver
package seg7_pkg;
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_DP = 7;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble_i -> active-high {g..a} glyph_o
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] glyph_o
);
  always_comb begin
    case (nib_i)
      4'h0: glyph_o = GLYPH_0;
      4'h1: glyph_o = GLYPH_1;
      4'h2: glyph_o = GLYPH_2;
      4'h3: glyph_o = GLYPH_3;
      4'h4: glyph_o = GLYPH_4;
      4'h5: glyph_o = GLYPH_5;
      4'h6: glyph_o = GLYPH_6;
      4'h7: glyph_o = GLYPH_7;
      4'h8: glyph_o = GLYPH_8;
      4'h9: glyph_o = GLYPH_9;
      4'hA: glyph_o = GLYPH_A;
      4'hB: glyph_o = GLYPH_B;
      4'hC: glyph_o = GLYPH_C;
      4'hD: glyph_o = GLYPH_D;
      4'hE: glyph_o = GLYPH_E;
      default: glyph_o = GLYPH_F;
    endcase
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed N-digit 7-segment driver; clk_i/reset_i/en_i/load_i + value/dp/blink/blank_lz in, seg_o/sel_o/frame_done_o out
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 10,
  parameter int DEAD_CYCLES    = 1,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic                  load_i,
  input  logic [4*N_DIGITS-1:0] value_i,
  input  logic [N_DIGITS-1:0]   dp_mask_i,
  input  logic [N_DIGITS-1:0]   blink_mask_i,
  input  logic                  blank_lz_i,
  output logic [7:0]            seg_o,
  output logic [N_DIGITS-1:0]   sel_o,
  output logic                  frame_done_o
);
  localparam int CW = clog2_min1(REFRESH_DIV);
  localparam int IW = clog2_min1(N_DIGITS);
  localparam int BW = clog2_min1(BLINK_FRAMES);
  localparam int DW = 6 * N_DIGITS + 1;
  localparam logic [7:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [N_DIGITS-1:0] SEL_INV = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] bl_cnt_q;
  logic phase_q, pend_q, fd_q;
  logic [7:0] seg_q, seg_d;
  logic [N_DIGITS-1:0] sel_q, sel_d;
  // display buffers packed as {blank_lz, blink_mask, dp_mask, value}
  logic [DW-1:0] in_buf, pend_buf_q, act_buf_q;
  logic [4*N_DIGITS-1:0] act_val;
  logic [N_DIGITS-1:0] act_dp, act_bl, hz;
  logic act_lz, tc, last, wrap, dead, blink_off, lz_blank, bl_tc;
  logic [3:0] nib;
  logic [6:0] glyph;
  assign in_buf = {blank_lz_i, blink_mask_i, dp_mask_i, value_i};
  assign {act_lz, act_bl, act_dp, act_val} = act_buf_q;
  seg7_hex_decode u_dec (.nib_i(nib), .glyph_o(glyph));
  always_comb begin
    tc = cnt_q == CW'(REFRESH_DIV - 1);
    last = idx_q == IW'(N_DIGITS - 1);
    wrap = en_i && tc && last;
    bl_tc = bl_cnt_q == BW'(BLINK_FRAMES - 1);
    cnt_d = !en_i ? cnt_q : tc ? '0 : cnt_q + 1'b1;
    idx_d = !(en_i && tc) ? idx_q : last ? '0 : idx_q + 1'b1;
    dead = !en_i || int'(cnt_q) < DEAD_CYCLES;
    nib = act_val[{idx_q, 2'b00} +: 4];
    // hz[i]: nibbles i..N-1 are all zero
    hz = '0;
    hz[N_DIGITS-1] = act_val[4*N_DIGITS-1 -: 4] == 4'h0;
    for (int i = N_DIGITS - 2; i >= 0; i--) hz[i] = hz[i+1] && act_val[4*i +: 4] == 4'h0;
    lz_blank = act_lz && idx_q != '0 && hz[idx_q];
    blink_off = !phase_q && act_bl[idx_q];
    seg_d = (dead || blink_off) ? 8'h00 : {act_dp[idx_q], lz_blank ? 7'h00 : glyph};
    sel_d = dead ? '0 : {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      idx_q <= '0;
      bl_cnt_q <= '0;
      phase_q <= 1'b1;
      pend_q <= 1'b0;
      pend_buf_q <= '0;
      act_buf_q <= '0;
      fd_q <= 1'b0;
      seg_q <= SEG_INV;
      sel_q <= SEL_INV;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      fd_q <= wrap;
      seg_q <= seg_d ^ SEG_INV;
      sel_q <= sel_d ^ SEL_INV;
      pend_buf_q <= load_i ? in_buf : pend_buf_q;
      pend_q <= !wrap && (pend_q || load_i);
      // a load landing on the wrap cycle goes straight to the active buffer
      act_buf_q <= (wrap && load_i) ? in_buf : (wrap && pend_q) ? pend_buf_q : act_buf_q;
      bl_cnt_q <= !wrap ? bl_cnt_q : bl_tc ? '0 : bl_cnt_q + 1'b1;
      phase_q <= (wrap && bl_tc) ? !phase_q : phase_q;
    end
  end
  assign seg_o = seg_q;
  assign sel_o = sel_q;
  assign frame_done_o = fd_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, load = 1'b0, blz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] dp = '0, bl = '0;
  logic [7:0] seg, seg2;
  logic [3:0] sel, sel2;
  logic fd, fd2;
  int n_chk = 0, n_fail = 0, wraps = 0;
  logic mid_go = 1'b0;
  logic [15:0] mid_val = '0;
  seg7_scan_ctrl #(.N_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1), .BLINK_FRAMES(2),
    .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) dut (
    .clk_i(clk), .reset_i(reset), .en_i(en), .load_i(load), .value_i(value),
    .dp_mask_i(dp), .blink_mask_i(bl), .blank_lz_i(blz),
    .seg_o(seg), .sel_o(sel), .frame_done_o(fd));
  seg7_scan_ctrl #(.N_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1), .BLINK_FRAMES(2),
    .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut_inv (
    .clk_i(clk), .reset_i(reset), .en_i(en), .load_i(load), .value_i(value),
    .dp_mask_i(dp), .blink_mask_i(bl), .blank_lz_i(blz),
    .seg_o(seg2), .sel_o(sel2), .frame_done_o(fd2));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic load_data(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b, input logic z);
    value = v;
    dp = d;
    bl = b;
    blz = z;
    load = 1'b1;
  endtask
  task automatic wait_frame(input string tag);
    for (int k = 0; k < 200; k++) begin
      tick;
      load = 1'b0;
      if (fd) break;
    end
    chk(tag, 32'(fd), 32'd1);
    wraps++;
  endtask
  // g packs expected {d3,d2,d1,d0} lit-slot segments; b is the active blink mask
  task automatic check_frame(input string tag, input logic [31:0] g, input logic [3:0] b);
    logic on;
    on = ((wraps / 2) % 2) == 0;
    for (int c = 1; c <= 16; c++) begin
      int j, k;
      j = (c - 1) / 4;
      k = (c - 1) % 4;
      tick;
      load = 1'b0;
      if (k == 0) begin
        chk($sformatf("%s c%0d dead sel", tag, c), 32'(sel), 32'd0);
        chk($sformatf("%s c%0d dead seg", tag, c), 32'(seg), 32'd0);
      end else begin
        chk($sformatf("%s c%0d sel", tag, c), 32'(sel), 32'd1 << j);
        chk($sformatf("%s c%0d seg", tag, c), 32'(seg), (b[j] && !on) ? 32'd0 : 32'(g[j*8 +: 8]));
      end
      chk($sformatf("%s c%0d frame_done", tag, c), 32'(fd), 32'(c == 16));
      if (mid_go && c == 8) begin
        value = mid_val;
        load = 1'b1;
        mid_go = 1'b0;
      end
    end
    wraps++;
  endtask
  initial begin
    tick;
    tick;
    chk("reset seg", 32'(seg), 32'h00);
    chk("reset sel", 32'(sel), 32'h0);
    chk("reset frame_done", 32'(fd), 32'd0);
    chk("reset seg inv", 32'(seg2), 32'hFF);
    chk("reset sel inv", 32'(sel2), 32'hF);
    reset = 1'b0;
    en = 1'b1;
    load_data(16'h1234, 4'h0, 4'h0, 1'b0);
    wait_frame("first wrap");
    check_frame("v1234", 32'h065B4F66, 4'h0);
    load_data(16'h0042, 4'h0, 4'h0, 1'b1);
    check_frame("v1234 held", 32'h065B4F66, 4'h0);
    check_frame("v0042 lz", 32'h0000665B, 4'h0);
    load_data(16'h0000, 4'h0, 4'h0, 1'b1);
    check_frame("v0042 held", 32'h0000665B, 4'h0);
    check_frame("v0000 lz", 32'h0000003F, 4'h0);
    load_data(16'h5678, 4'b0100, 4'b0001, 1'b0);
    check_frame("v0000 held", 32'h0000003F, 4'h0);
    check_frame("blink f1", 32'h6DFD077F, 4'b0001);
    check_frame("blink f2", 32'h6DFD077F, 4'b0001);
    check_frame("blink f3", 32'h6DFD077F, 4'b0001);
    check_frame("blink f4", 32'h6DFD077F, 4'b0001);
    load_data(16'hAAAA, 4'h0, 4'h0, 1'b0);
    mid_val = 16'hBBBB;
    mid_go = 1'b1;
    check_frame("double load old", 32'h6DFD077F, 4'b0001);
    check_frame("last load wins", 32'h7C7C7C7C, 4'h0);
    for (int c = 1; c <= 6; c++) tick;
    en = 1'b0;
    for (int c = 7; c <= 16; c++) begin
      tick;
      chk($sformatf("en0 c%0d sel", c), 32'(sel), 32'h0);
      chk($sformatf("en0 c%0d frame_done", c), 32'(fd), 32'd0);
    end
    en = 1'b1;
    tick;
    chk("resume sel", 32'(sel), 32'h2);
    chk("resume seg", 32'(seg), 32'h7C);
    for (int c = 18; c <= 25; c++) begin
      tick;
      chk($sformatf("resume c%0d frame_done", c), 32'(fd), 32'd0);
    end
    tick;
    chk("stretched frame_done", 32'(fd), 32'd1);
    wraps++;
    tick;
    tick;
    tick;
    chk("pre-reset sel", 32'(sel), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async reset seg", 32'(seg), 32'h00);
    chk("async reset sel", 32'(sel), 32'h0);
    chk("async reset seg inv", 32'(seg2), 32'hFF);
    chk("async reset sel inv", 32'(sel2), 32'hF);
    chk("async reset frame_done", 32'(fd), 32'd0);
    tick;
    tick;
    reset = 1'b0;
    wraps = 0;
    tick;
    chk("post reset dead sel", 32'(sel), 32'h0);
    chk("post reset dead sel inv", 32'(sel2), 32'hF);
    tick;
    chk("post reset sel", 32'(sel), 32'h1);
    chk("post reset seg", 32'(seg), 32'h3F);
    chk("post reset sel inv", 32'(sel2), 32'hE);
    chk("post reset seg inv", 32'(seg2), 32'hC0);
    load_data(16'h0008, 4'h0, 4'h0, 1'b0);
    wait_frame("post reset wrap");
    tick;
    tick;
    chk("digit8 sel", 32'(sel), 32'h1);
    chk("digit8 seg", 32'(seg), 32'h7F);
    chk("digit8 seg inv", 32'(seg2), 32'h80);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
